instr_bus_router: RTL and testbench
===================================

# instr_bus_router

Parametrised instruction-bus router between the core's instruction fetch port and NUM_SLAVES instruction memories (boot ROM, code RAM, further banks). Decodes each request against a per-slave base/mask map and forwards the req/gnt handshake to the selected slave. Tracks up to MAX_OUTSTANDING granted fetches in a FIFO and returns the responses to the core in order. Unmapped addresses are answered by an internal decode-error responder.

## Interface
- NUM_SLAVES, 2: number of slave ports, 1..8.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered fetches, 1..8.
- SLAVE_BASE, package default INSTR_BUS_SLAVE_BASE: array of NUM_SLAVES 32-bit base addresses. Defaults are boot ROM 32'h0000_0000 and code RAM 32'h0001_0000.
- SLAVE_MASK, package default INSTR_BUS_SLAVE_MASK: array of NUM_SLAVES 32-bit masks. Defaults are 32'hFFFF_F000 (4 KiB) and 32'hFFFF_0000 (64 KiB).
- clk  in  1  single clock; everything in this block is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- m_req  in  1  fetch request from the core.
- m_addr  in  32  fetch address.
- m_gnt  out  1  request accepted this cycle.
- m_rvalid  out  1  response valid.
- m_rdata  out  32  response instruction word.
- m_err  out  1  response is a decode error; valid only with m_rvalid.
- s_req  out  NUM_SLAVES  per-slave request.
- s_addr  out  32  shared address to all slaves; equals m_addr.
- s_gnt  in  NUM_SLAVES  per-slave grant.
- s_rvalid  in  NUM_SLAVES  per-slave response valid.
- s_rdata  in  NUM_SLAVES×32  per-slave read data.
- busy  out  1  at least one fetch is outstanding.

## Operation
- **Decode (combinational):** slave i matches when (m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]. If several match, the lowest index wins. No match selects target index NUM_SLAVES (DECERR).
- **Outstanding count:** `count` has width $clog2(MAX_OUTSTANDING+1). The tracking FIFO stores the target index of each granted fetch.
- **Issue rule:** a request may proceed only when count < MAX_OUTSTANDING and either count == 0 or the target equals the FIFO tail entry. Responses therefore never reorder between slaves with different latencies.
- **Forwarding:** if the request may proceed and the target is a real slave, then s_req[target] = m_req, m_gnt = s_gnt[target], and all other s_req bits are 0. If it may not proceed, all s_req bits are 0 and m_gnt = 0.
- **DECERR grant:** when the request may proceed and the target is DECERR, m_gnt = m_req.
- **Push and pop:** m_req & m_gnt pushes the target and increments count. A response pops the FIFO head and decrements count. A push and a pop in the same cycle leave count unchanged.
- **Response path:** m_rvalid = s_rvalid[head] when count > 0 and head is a real slave. m_rdata = s_rdata[head], m_err = 0.
- **Stray responses:** s_rvalid from a non-head slave, or any s_rvalid while count == 0, is ignored.
- **DECERR responder:** a registered flag err_rvalid is set one cycle after a DECERR grant. While head is DECERR, m_rvalid = err_rvalid, m_rdata = 32'h0, m_err = 1 (see Configuration).
- **busy** = (count != 0).

## Timing
- Reset values: count = 0, FIFO pointers = 0, err_rvalid = 0. Consequently m_gnt, m_rvalid, m_err, busy and s_req are all 0 while count = 0 and m_req = 0.
- Grant is combinational, in the same cycle as request.
- A real-slave response reaches the core with zero added latency. A DECERR response arrives exactly 1 cycle after its grant.
- Back-to-back DECERR grants produce back-to-back responses, one per cycle.
- Full (count == MAX_OUTSTANDING): m_gnt = 0 even if a pop happens in the same cycle; there is no bypass.
- Reset asserted mid-operation: all tracking is discarded immediately. Slave responses arriving after reset release are ignored, because count = 0.
- FIFO pointers wrap modulo MAX_OUTSTANDING; non-power-of-two depths are supported.

## Configuration
- INSTR_BUS_ROUTER_DECERR_EN defined: behaviour is as described above; m_err = 1 on unmapped responses.
- INSTR_BUS_ROUTER_DECERR_EN not defined: unmapped fetches are still granted and answered 1 cycle later with m_rdata = 32'h0000_0013 (NOP). m_err is tied to 0.

## Structure
- pixel_riscv_soc_pkg holds:
  - INSTR_BUS_MAX_SLAVES;
  - INSTR_BUS_SLAVE_BASE and INSTR_BUS_SLAVE_MASK default arrays;
  - the named slave indices INSTR_BUS_IDX_BOOT_ROM = 0 and INSTR_BUS_IDX_CODE_RAM = 1;
  - the constant INSTR_BUS_NOP = 32'h0000_0013.
- One sub-module, instr_bus_track_fifo, holds the target-index storage, pointers, count and full/empty flags. It is parametrised by depth and entry width.

## Test plan
- Fetch at 32'h0000_0100 with s_gnt[0] = 1 and a ROM response 1 cycle later carrying 32'hDEAD_BEEF → m_gnt = 1 in the request cycle, s_req = 2'b01, next cycle m_rvalid = 1, m_rdata = 32'hDEAD_BEEF, busy returns to 0.
- Two back-to-back fetches to the RAM at 32'h0001_0000 and 32'h0001_0004, slave latency 3 cycles → both granted, count = 2. A third RAM fetch is stalled (m_gnt = 0) until the first response arrives.
- ROM fetch outstanding, then a RAM fetch → RAM s_req held at 0 until the ROM response pops, then granted. Responses arrive in order.
- Fetch at 32'h8000_0000 → granted. With INSTR_BUS_ROUTER_DECERR_EN: m_rvalid = 1, m_err = 1, m_rdata = 0 one cycle later. Without it: m_rdata = 32'h0000_0013, m_err = 0.
- Assert rst_n low with 2 fetches outstanding, release, then drive a late s_rvalid[1] → m_rvalid stays 0, count = 0, busy = 0.

Source files
------------

// File: rtl/pixel_riscv_soc_pkg.sv
// pixel_riscv_soc_pkg: shared instruction-bus constants (slave map defaults, named slave indices, NOP word)
package pixel_riscv_soc_pkg;
  localparam int INSTR_BUS_MAX_SLAVES = 8;
  localparam int INSTR_BUS_IDX_BOOT_ROM = 0;
  localparam int INSTR_BUS_IDX_CODE_RAM = 1;
  // Packed arrays: rightmost element is index 0 (boot ROM), next is index 1 (code RAM).
  localparam logic [1:0][31:0] INSTR_BUS_SLAVE_BASE = {32'h0001_0000, 32'h0000_0000};
  localparam logic [1:0][31:0] INSTR_BUS_SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_F000};
  localparam logic [31:0] INSTR_BUS_NOP = 32'h0000_0013;
endpackage

// File: rtl/instr_bus_track_fifo.sv
// instr_bus_track_fifo: in-order tracker of granted fetch targets
// Ports: clk, rst_n (async active-low), push/din (append target), pop (drop oldest),
//        head (oldest target), tail (newest target), full, empty.
module instr_bus_track_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail,
  output logic             full,
  output logic             empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[rd_ptr_q];
  assign tail = mem_q[wr_ptr_q == '0 ? LAST : wr_ptr_q - 1'b1];
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/instr_bus_router.sv
// instr_bus_router: decodes core fetches onto NUM_SLAVES instruction memories and returns responses in order
// Ports: clk, rst_n (async active-low); core side m_req/m_addr/m_gnt/m_rvalid/m_rdata/m_err;
//        slave side s_req/s_addr/s_gnt/s_rvalid/s_rdata (slave i at bits [i*32 +: 32]); busy.
// Macro INSTR_BUS_ROUTER_DECERR_EN: unmapped fetches answer with m_err=1 and zero data;
//        when undefined they answer with a NOP word and m_err stays 0.
module instr_bus_router
  import pixel_riscv_soc_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_BASE = INSTR_BUS_SLAVE_BASE,
  parameter logic [NUM_SLAVES-1:0][31:0] SLAVE_MASK = INSTR_BUS_SLAVE_MASK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_req,
  input  logic [31:0]              m_addr,
  output logic                     m_gnt,
  output logic                     m_rvalid,
  output logic [31:0]              m_rdata,
  output logic                     m_err,
  output logic [NUM_SLAVES-1:0]    s_req,
  output logic [31:0]              s_addr,
  input  logic [NUM_SLAVES-1:0]    s_gnt,
  input  logic [NUM_SLAVES-1:0]    s_rvalid,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     busy
);
  localparam int TW = $clog2(NUM_SLAVES + 1);
  localparam logic [TW-1:0] DECERR = TW'(NUM_SLAVES);
`ifdef INSTR_BUS_ROUTER_DECERR_EN
  localparam logic [31:0] ERR_DATA = 32'h0;
`else
  localparam logic [31:0] ERR_DATA = INSTR_BUS_NOP;
`endif
  logic [TW-1:0] tgt, head, tail;
  logic full, empty, push, pop, can_issue;
  logic err_rvalid_q, err_rvalid_d;
  logic [NUM_SLAVES:0] gnt_ext, rv_ext;
  logic [NUM_SLAVES:0][31:0] rd_ext;
  // Scan from the top so the lowest matching index ends up selected.
  always_comb begin
    tgt = DECERR;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) tgt = TW'(i);
  end
  // Index NUM_SLAVES of each extended vector is the internal error responder.
  assign gnt_ext = {1'b1, s_gnt};
  assign rv_ext = {err_rvalid_q, s_rvalid};
  assign rd_ext = {ERR_DATA, s_rdata};
  // Only one target may be in flight at a time, so responses can never reorder.
  assign can_issue = !full && (empty || tgt == tail);
  assign m_gnt = m_req && can_issue && gnt_ext[tgt];
  always_comb begin
    s_req = '0;
    for (int i = 0; i < NUM_SLAVES; i++) s_req[i] = m_req && can_issue && tgt == TW'(i);
  end
  assign push = m_gnt;
  assign m_rvalid = !empty && rv_ext[head];
  assign pop = m_rvalid;
  assign m_rdata = rd_ext[head];
`ifdef INSTR_BUS_ROUTER_DECERR_EN
  assign m_err = m_rvalid && head == DECERR;
`else
  assign m_err = 1'b0;
`endif
  assign busy = !empty;
  assign s_addr = m_addr;
  assign err_rvalid_d = push && tgt == DECERR;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_rvalid_q <= 1'b0;
    else err_rvalid_q <= err_rvalid_d;
  end
  instr_bus_track_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(TW)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(tgt),
    .head(head),
    .tail(tail),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_instr_bus_router.sv
// tb_instr_bus_router: randomized and directed checks of instr_bus_router against a queue-based model
module tb_instr_bus_router;
  localparam int NS = 2;
  localparam int MO = 2;
  localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h0001_0000};
  localparam logic [31:0] MASK [NS] = '{32'hFFFF_F000, 32'hFFFF_0000};
`ifdef INSTR_BUS_ROUTER_DECERR_EN
  localparam logic [31:0] ERR_DATA = 32'h0;
  localparam logic ERR_BIT = 1'b1;
`else
  localparam logic [31:0] ERR_DATA = 32'h0000_0013;
  localparam logic ERR_BIT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_req = 1'b0;
  logic [31:0] m_addr = '0;
  logic m_gnt, m_rvalid, m_err, busy;
  logic [31:0] m_rdata, s_addr;
  logic [NS-1:0] s_req;
  logic [NS-1:0] s_gnt = '0;
  logic [NS-1:0] s_rvalid = '0;
  logic [NS*32-1:0] s_rdata = '0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_due = 0;
  int oq[$];
  int due[$];
  bit err_flag = 1'b0;
  bit auto_slv = 1'b0;

  instr_bus_router #(.NUM_SLAVES(NS), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_gnt(m_gnt),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err), .s_req(s_req),
    .s_addr(s_addr), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & MASK[i]) == BASE[i]) return i;
    return NS;
  endfunction

  task automatic set_in(input bit req, input logic [31:0] addr, input logic [NS-1:0] g,
                        input logic [NS-1:0] rv, input logic [31:0] rd);
    m_req = req;
    m_addr = addr;
    s_gnt = g;
    s_rvalid = rv;
    s_rdata = {rd, rd};
  endtask

  // Called just after a falling edge with inputs applied: checks outputs, then advances the model at the rising edge.
  task automatic cycle();
    int t, h, d;
    bit can, eg, erv;
    logic [NS-1:0] esreq;
    #1;
    t = decode(m_addr);
    can = oq.size() < MO && (oq.size() == 0 || oq[$] == t);
    eg = m_req && can && (t == NS || s_gnt[t]);
    esreq = '0;
    if (m_req && can && t < NS) esreq[t] = 1'b1;
    h = oq.size() != 0 ? oq[0] : -1;
    erv = h >= 0 && (h == NS ? err_flag : s_rvalid[h]);
    chk("m_gnt", 32'(m_gnt), 32'(eg));
    chk("s_req", 32'(s_req), 32'(esreq));
    chk("m_rvalid", 32'(m_rvalid), 32'(erv));
    chk("busy", 32'(busy), 32'(oq.size() != 0));
    chk("s_addr", s_addr, m_addr);
    if (erv) begin
      chk("m_rdata", m_rdata, h == NS ? ERR_DATA : s_rdata[h*32 +: 32]);
      chk("m_err", 32'(m_err), 32'(h == NS && ERR_BIT));
    end
    @(posedge clk);
    if (erv) begin
      void'(oq.pop_front());
      if (h < NS && auto_slv) void'(due.pop_front());
    end
    if (eg) begin
      oq.push_back(t);
      if (t < NS && auto_slv) begin
        d = cyc + 1 + int'($urandom_range(0, 2));
        if (d <= last_due) d = last_due + 1;
        due.push_back(d);
        last_due = d;
      end
    end
    err_flag = eg && t == NS;
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_drive(input bit allow_req);
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0: a = {20'h0, 12'($urandom())};
      1: a = {16'h0001, 16'($urandom())};
      2: a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: a = $urandom();
    endcase
    m_req = allow_req && $urandom_range(0, 9) < 7;
    m_addr = a;
    for (int i = 0; i < NS; i++) s_gnt[i] = $urandom_range(0, 3) != 0;
    s_rdata = {$urandom(), $urandom()};
    for (int i = 0; i < NS; i++)
      if (oq.size() != 0 && oq[0] == i) s_rvalid[i] = due.size() != 0 && due[0] <= cyc;
      else s_rvalid[i] = $urandom_range(0, 4) == 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    set_in(0, 32'h0, '0, '0, 32'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    // single ROM fetch
    set_in(1, 32'h0000_0100, 2'b01, 2'b00, 32'h0);
    #1;
    chk("rom_gnt", 32'(m_gnt), 32'd1);
    chk("rom_sreq", 32'(s_req), 32'b01);
    cycle();
    set_in(0, 32'h0, 2'b00, 2'b01, 32'hDEAD_BEEF);
    #1;
    chk("rom_rvalid", 32'(m_rvalid), 32'd1);
    chk("rom_rdata", m_rdata, 32'hDEAD_BEEF);
    cycle();
    set_in(0, 32'h0, '0, '0, 32'h0);
    #1;
    chk("rom_idle_busy", 32'(busy), 32'd0);
    cycle();
    // two RAM fetches fill the tracker; third stalls until a pop has happened
    set_in(1, 32'h0001_0000, 2'b10, 2'b00, 32'h0);
    cycle();
    set_in(1, 32'h0001_0004, 2'b10, 2'b00, 32'h0);
    cycle();
    set_in(1, 32'h0001_0008, 2'b10, 2'b00, 32'h0);
    #1;
    chk("ram_full_stall", 32'(m_gnt), 32'd0);
    chk("ram_full_busy", 32'(busy), 32'd1);
    cycle();
    set_in(1, 32'h0001_0008, 2'b10, 2'b10, 32'h0000_00A0);
    #1;
    chk("ram_full_nobypass", 32'(m_gnt), 32'd0);
    chk("ram_first_rdata", m_rdata, 32'h0000_00A0);
    cycle();
    set_in(1, 32'h0001_0008, 2'b10, 2'b10, 32'h0000_00A4);
    #1;
    chk("ram_grant_after_pop", 32'(m_gnt), 32'd1);
    cycle();
    set_in(0, 32'h0, '0, '0, 32'h0);
    cycle();
    cycle();
    set_in(0, 32'h0, '0, 2'b10, 32'h0000_00A8);
    #1;
    chk("ram_third_rdata", m_rdata, 32'h0000_00A8);
    cycle();
    set_in(0, 32'h0, '0, '0, 32'h0);
    #1;
    chk("ram_idle_busy", 32'(busy), 32'd0);
    cycle();
    // ROM outstanding blocks a RAM fetch, even in the cycle the ROM answers
    set_in(1, 32'h0000_0200, 2'b01, 2'b00, 32'h0);
    cycle();
    set_in(1, 32'h0001_0020, 2'b11, 2'b00, 32'h0);
    #1;
    chk("order_block_sreq", 32'(s_req), 32'd0);
    chk("order_block_gnt", 32'(m_gnt), 32'd0);
    cycle();
    set_in(1, 32'h0001_0020, 2'b11, 2'b01, 32'h1111_1111);
    #1;
    chk("order_pop_sreq", 32'(s_req), 32'd0);
    chk("order_rom_rdata", m_rdata, 32'h1111_1111);
    cycle();
    set_in(1, 32'h0001_0020, 2'b11, 2'b00, 32'h0);
    #1;
    chk("order_ram_sreq", 32'(s_req), 32'b10);
    cycle();
    set_in(0, 32'h0, '0, 2'b10, 32'h2222_2222);
    #1;
    chk("order_ram_rdata", m_rdata, 32'h2222_2222);
    cycle();
    // unmapped fetch answered by the internal responder one cycle later
    set_in(1, 32'h8000_0000, 2'b00, 2'b00, 32'h0);
    #1;
    chk("decerr_gnt", 32'(m_gnt), 32'd1);
    chk("decerr_sreq", 32'(s_req), 32'd0);
    cycle();
    set_in(0, 32'h0, '0, '0, 32'h5555_5555);
    #1;
    chk("decerr_rvalid", 32'(m_rvalid), 32'd1);
    chk("decerr_rdata", m_rdata, ERR_DATA);
    chk("decerr_err", 32'(m_err), 32'(ERR_BIT));
    cycle();
    repeat (4) begin
      set_in(1, 32'h8000_0040, 2'b00, 2'b00, 32'h0);
      cycle();
    end
    set_in(0, 32'h0, '0, '0, 32'h0);
    #1;
    chk("decerr_b2b_rvalid", 32'(m_rvalid), 32'd1);
    cycle();
    cycle();
    // reset with two fetches outstanding; a late response must be ignored
    set_in(1, 32'h0001_0000, 2'b10, 2'b00, 32'h0);
    cycle();
    set_in(1, 32'h0001_0004, 2'b10, 2'b00, 32'h0);
    cycle();
    set_in(0, 32'h0, '0, '0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_now", 32'(busy), 32'd0);
    oq.delete();
    due.delete();
    err_flag = 1'b0;
    cycle();
    rst_n = 1'b1;
    set_in(0, 32'h0, '0, 2'b10, 32'h7777_7777);
    #1;
    chk("late_rvalid", 32'(m_rvalid), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    cycle();
    // randomized traffic with latency 1..3 slaves and stray responses
    auto_slv = 1'b1;
    last_due = cyc;
    repeat (600) begin
      rand_drive(1'b1);
      cycle();
    end
    repeat (12) begin
      rand_drive(1'b0);
      cycle();
    end
    set_in(0, 32'h0, '0, '0, 32'h0);
    #1;
    chk("drain_busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
